// File: rtl/sd_sdram_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_sdram_writer_if
//  Description : Burst-write bus between the SD picture writer and the SDRAM
//                controller (request/grant handshake, address, data pull).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sd_sdram_writer_if #(
   parameter int ADDR_W = 22
);
   logic              wr_req;
   logic              wr_ack;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_data_req;
   logic [15:0]       wr_data;

   // Writer side: raises requests and supplies address/data
   modport master (
      output wr_req,
      output wr_addr,
      output wr_data,
      input  wr_ack,
      input  wr_data_req
   );

   // Controller side: grants requests and pulls data words
   modport slave (
      input  wr_req,
      input  wr_addr,
      input  wr_data,
      output wr_ack,
      output wr_data_req
   );
endinterface
`default_nettype wire

// File: rtl/sd_sdram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_sdram_writer
//  Description : Buffers 16-bit pixel words from the SD sector reader in a
//                show-ahead FIFO and writes them to SDRAM in fixed-length
//                bursts, advancing the address and wrapping once per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_sdram_writer #(
   parameter int BURST_LEN   = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int FRAME_WORDS = 786432,
   parameter int ADDR_W      = 22
)(
   input  wire logic          SD_clk,
   input  wire logic          rst_n,
   input  wire logic [15:0]   mydata_i,
   input  wire logic          myvalid_i,
   sd_sdram_writer_if.master  wr_bus,
   output logic               frame_done,
   output logic               overflow,
   output logic               busy
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BEAT_W = $clog2(BURST_LEN + 1);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_req  = 2'd1;
   localparam logic [1:0] c_st_xfer = 2'd2;

   // Address sum is one bit wider so a frame size of 2**ADDR_W still compares
   localparam logic [ADDR_W:0] c_frame_end = (ADDR_W+1)'(FRAME_WORDS);
   localparam logic [ADDR_W:0] c_burst_inc = (ADDR_W+1)'(BURST_LEN);

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [15:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic [BEAT_W-1:0] r_beat;
   logic [ADDR_W-1:0] r_addr;
   logic              r_frame_done;
   logic              r_overflow;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_last_beat;
   logic [ADDR_W:0]   w_addr_sum;

   assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = myvalid_i && !w_full;
   // Pops only happen inside a granted burst and never from an empty FIFO
   assign w_pop       = (r_state == c_st_xfer) && wr_bus.wr_data_req && !w_empty;
   assign w_last_beat = w_pop && (r_beat == BEAT_W'(BURST_LEN - 1));
   assign w_addr_sum  = {1'b0, r_addr} + c_burst_inc;

   // Head word is forced to zero when empty so reset shows a clean bus
   assign wr_bus.wr_data = w_empty ? 16'h0000 : r_mem[r_rptr];
   assign wr_bus.wr_addr = r_addr;
   assign frame_done     = r_frame_done;
   assign overflow       = r_overflow;

   // Storage array: written on every accepted word, contents need no reset
   always_ff @(posedge SD_clk) begin
      if (w_push) r_mem[r_wptr] <= mydata_i;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge SD_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (myvalid_i && w_full) r_overflow <= 1'b1;
      end
   end

   // Beat counter, burst address advance with frame wrap, frame_done pulse
   always_ff @(posedge SD_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat       <= '0;
         r_addr       <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_last_beat) begin
            r_beat <= '0;
            if (w_addr_sum == c_frame_end) begin
               r_addr       <= '0;
               r_frame_done <= 1'b1;
            end else begin
               r_addr <= w_addr_sum[ADDR_W-1:0];
            end
         end else if (w_pop) begin
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   // Burst FSM state register
   always_ff @(posedge SD_clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_st_idle;
      else        r_state <= w_state_next;
   end

   // Burst FSM next-state: request once a full burst is buffered
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: if (r_count >= CNT_W'(BURST_LEN)) w_state_next = c_st_req;
         c_st_req:  if (wr_bus.wr_ack)                w_state_next = c_st_xfer;
         c_st_xfer: if (w_last_beat)                  w_state_next = c_st_idle;
         default:                                     w_state_next = c_st_idle;
      endcase
   end

   // Burst FSM outputs decoded from the registered state
   always_comb begin
      wr_bus.wr_req = (r_state == c_st_req);
      busy          = (r_state != c_st_idle);
   end

endmodule
`default_nettype wire

// File: tb/tb_sd_sdram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_sdram_writer
//  Description : Self-checking bench for sd_sdram_writer: vector table,
//                directed corner sequences and random traffic against a
//                queue-based transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_sdram_writer;

   localparam int BL = 8;
   localparam int FD = 16;
   localparam int FW = 64;
   localparam int AW = 22;

   logic        SD_clk    = 1'b0;
   logic        rst_n     = 1'b1;
   logic [15:0] mydata_i  = 16'h0;
   logic        myvalid_i = 1'b0;
   logic        frame_done;
   logic        overflow;
   logic        busy;

   sd_sdram_writer_if #(.ADDR_W(AW)) bus ();

   sd_sdram_writer #(
      .BURST_LEN   (BL),
      .FIFO_DEPTH  (FD),
      .FRAME_WORDS (FW),
      .ADDR_W      (AW)
   ) dut (
      .SD_clk     (SD_clk),
      .rst_n      (rst_n),
      .mydata_i   (mydata_i),
      .myvalid_i  (myvalid_i),
      .wr_bus     (bus),
      .frame_done (frame_done),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 SD_clk = ~SD_clk;

   // ---------------- transaction-level reference model ----------------
   typedef enum int {M_IDLE, M_GRANT, M_MOVE} mphase_t;
   logic [15:0] m_q[$];
   mphase_t     m_phase = M_IDLE;
   int          m_beats = 0;
   int          m_addr  = 0;
   bit          m_ovf   = 1'b0;
   bit          m_fd    = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int n_fd  = 0;

   typedef struct {
      bit          v;
      logic [15:0] d;
      bit          ack;
      bit          dreq;
      bit          e_req;
      bit          e_busy;
      logic [21:0] e_addr;
      logic [15:0] e_data;
   } vec_t;
   vec_t tbl[18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] dut_pack();
      return {22'h0, bus.wr_req, busy, frame_done, overflow, bus.wr_addr, bus.wr_data};
   endfunction

   function automatic logic [63:0] exp_pack();
      logic [15:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 16'h0000;
      return {22'h0, (m_phase == M_GRANT), (m_phase != M_IDLE), m_fd, m_ovf, AW'(m_addr), head};
   endfunction

   // One clock: drive inputs, advance the model, compare after the edge
   task automatic cycle(input bit v, input logic [15:0] d, input bit ack, input bit dreq);
      int          sz;
      bit          pop;
      bit          push;
      logic [15:0] tmp;
      myvalid_i       = v;
      mydata_i        = d;
      bus.wr_ack      = ack;
      bus.wr_data_req = dreq;
      sz   = m_q.size();
      pop  = (m_phase == M_MOVE) && dreq && (sz > 0);
      push = v && (sz < FD);
      if (v && sz >= FD) m_ovf = 1'b1;
      m_fd = 1'b0;
      if (pop) begin
         tmp = m_q.pop_front();
         m_beats++;
      end
      if (push) m_q.push_back(d);
      case (m_phase)
         M_IDLE:  if (sz >= BL) m_phase = M_GRANT;
         M_GRANT: if (ack) m_phase = M_MOVE;
         default: if (pop && m_beats == BL) begin
                     m_phase = M_IDLE;
                     m_beats = 0;
                     m_addr += BL;
                     if (m_addr == FW) begin
                        m_addr = 0;
                        m_fd   = 1'b1;
                     end
                  end
      endcase
      @(posedge SD_clk);
      #1;
      check("model", dut_pack(), exp_pack());
      if (frame_done === 1'b1) n_fd++;
   endtask

   // Asynchronous reset mid-cycle; outputs must clear before any edge
   task automatic do_reset();
      #2;
      rst_n           = 1'b0;
      myvalid_i       = 1'b0;
      mydata_i        = 16'h0;
      bus.wr_ack      = 1'b0;
      bus.wr_data_req = 1'b0;
      m_q.delete();
      m_phase = M_IDLE;
      m_beats = 0;
      m_addr  = 0;
      m_ovf   = 1'b0;
      m_fd    = 1'b0;
      #1;
      check("reset_outputs", dut_pack(), exp_pack());
      @(negedge SD_clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.wr_ack      = 1'b0;
      bus.wr_data_req = 1'b0;

      // Basic burst vectors: 8 pushes, request, grant, 8 pulls
      for (int i = 0; i < 8; i++)
         tbl[i] = '{1'b1, 16'(i + 1), (i == 0), 1'b0, 1'b0, 1'b0, 22'd0, 16'h0001};
      tbl[8] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 22'd0, 16'h0001};
      tbl[9] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 22'd0, 16'h0001};
      for (int k = 0; k < 8; k++)
         tbl[10 + k] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, (k < 7),
                         (k == 7) ? 22'd8 : 22'd0, (k < 7) ? 16'(k + 2) : 16'h0};

      do_reset();
      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].ack, tbl[i].dreq);
         check($sformatf("tbl%0d_req", i),  bus.wr_req,  tbl[i].e_req);
         check($sformatf("tbl%0d_busy", i), busy,        tbl[i].e_busy);
         check($sformatf("tbl%0d_addr", i), bus.wr_addr, tbl[i].e_addr);
         check($sformatf("tbl%0d_data", i), bus.wr_data, tbl[i].e_data);
      end

      // Withheld grant: request holds, FIFO fills, 17th word overflows
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
      for (int j = 0; j < 20; j++) begin
         cycle(j < 9, 16'h0200 + 16'(j), 1'b0, 1'b1);
         if (j == 7) check("ovf_before_17th", overflow, 1'b0);
         if (j == 8) check("ovf_after_17th", overflow, 1'b1);
      end
      check("stall_req_high", bus.wr_req, 1'b1);
      check("stall_addr", bus.wr_addr, 22'd0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      for (int j = 0; j < 40; j++) cycle(1'b0, 16'h0, 1'b1, 1'b1);
      check("ovf_sticky", overflow, 1'b1);
      check("stall_drain_addr", bus.wr_addr, 22'd16);

      // Simultaneous push and pop with nine buffered words
      do_reset();
      for (int i = 0; i < 9; i++) cycle(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0B00 + 16'(i), 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) cycle(1'b0, 16'h0, 1'b1, 1'b1);

      // Data-request gap mid-burst
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0031 + 16'(i), 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 16'h0, 1'b0, 1'b0);
         check("gap_hold_data", bus.wr_data, 16'h0035);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("gap_done_busy", busy, 1'b0);
      check("gap_done_addr", bus.wr_addr, 22'd8);

      // Reset at beat 4 abandons the burst; next burst restarts at 0
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0D00 + 16'(i), 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      check("post_rst_req", bus.wr_req, 1'b1);
      check("post_rst_addr", bus.wr_addr, 22'd0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("post_rst_next_addr", bus.wr_addr, 22'd8);

      // One full frame with prompt grants
      do_reset();
      n_fd = 0;
      begin
         int pushed;
         pushed = 0;
         for (int c = 0; c < 400; c++) begin
            if ((c % 2 == 0) && pushed < FW) begin
               cycle(1'b1, 16'($urandom), 1'b1, 1'b1);
               pushed++;
            end else begin
               cycle(1'b0, 16'h0, 1'b1, 1'b1);
            end
         end
      end
      check("frame_pulses", n_fd, 1);
      check("frame_wrap_addr", bus.wr_addr, 22'd0);
      check("frame_idle", busy, 1'b0);

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++)
         cycle($urandom_range(0, 1) == 1, 16'($urandom),
               $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sd_sdram_writer.md
SD_SDRAM_WRITER -- requirements
Module: sd_sdram_writer

Interface
REQ-001 Parameter BURST_LEN, default 8, words per SDRAM write burst.
REQ-002 Parameter FIFO_DEPTH, default 16, capacity of the internal word FIFO; power of two and >= 2*BURST_LEN.
REQ-003 Parameter FRAME_WORDS, default 786432, 16-bit words per picture (1024*768); integer multiple of BURST_LEN.
REQ-004 Parameter ADDR_W, default 22, SDRAM word-address width.
REQ-005 SD_clk  input  1  sole clock; all logic rises on its posedge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 mydata_i  input  16  pixel word from the SD sector reader.
REQ-008 myvalid_i  input  1  one-cycle strobe; mydata_i is valid while high.
REQ-009 wr_req  output  1  burst write request to the SDRAM controller.
REQ-010 wr_ack  input  1  one-cycle grant from the controller for the pending request.
REQ-011 wr_addr  output  ADDR_W  burst start word address; stable while wr_req is high.
REQ-012 wr_data_req  input  1  controller pulls one word per cycle while high.
REQ-013 wr_data  output  16  FIFO head word (show-ahead).
REQ-014 frame_done  output  1  one-cycle pulse after the last burst of a frame is transferred.
REQ-015 overflow  output  1  sticky flag: a word was dropped because the FIFO was full.
REQ-016 busy  output  1  high in REQ and XFER states.

Function
REQ-017 FIFO: push on myvalid_i when not full; pop on wr_data_req in XFER state when not empty; wr_data always shows the current head.
REQ-018 Simultaneous push and pop keep the count unchanged and shall both take effect.
REQ-019 Push while full: word discarded, count unchanged, overflow set to 1 and held until reset.
REQ-020 FSM states: IDLE, REQ, XFER.
REQ-021 IDLE -> REQ when the FIFO count >= BURST_LEN; wr_req goes high on the next edge.
REQ-022 REQ: wr_req held high until the cycle wr_ack=1; next state XFER and wr_req low.
REQ-023 XFER: each cycle with wr_data_req=1 pops one word and increments the beat counter; wr_data_req=0 stalls without a pop.
REQ-024 XFER exits to IDLE on the cycle the BURST_LEN-th word pops; wr_addr advances by BURST_LEN on the same edge.
REQ-025 If the advanced address equals FRAME_WORDS, wr_addr wraps to 0 and frame_done pulses for exactly one cycle.
REQ-026 wr_data_req in IDLE or REQ shall be ignored, with no pop; wr_ack outside REQ shall be ignored.
REQ-027 A FIFO underflow during XFER (wr_data_req with FIFO empty) shall not pop or count a beat; the burst continues when data arrives.
REQ-028 Input acceptance continues in every state, including REQ and XFER.
REQ-029 Latency: a word pushed at edge N is visible on wr_data at edge N+1 if the FIFO was empty.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, FIFO empty, beat count 0, wr_addr 0, wr_req 0, frame_done 0, overflow 0; wr_data shall be 0.
REQ-031 Reset mid-burst abandons the burst without completing it; after release, operation resumes from address 0.
REQ-032 The first rising edge after rst_n deasserts shall be a normal operating edge.

Verification
REQ-033 Push 8 words 0x0001..0x0008 -> wr_req=1 with wr_addr=0; ack, then 8 wr_data_req cycles -> wr_data sequence 0x0001..0x0008, wr_addr=8, state IDLE.
REQ-034 Hold wr_ack low for 20 cycles -> wr_req stays high and wr_addr stays constant; pushes continue up to 16 words, and the 17th push sets overflow=1.
REQ-035 Stream FRAME_WORDS words with prompt acks -> exactly one frame_done pulse after the final beat, and wr_addr=0.
REQ-036 myvalid_i and a wr_data_req pop in the same cycle, with count 9 -> count stays 9 and data order is preserved.
REQ-037 Deassert wr_data_req for 3 cycles mid-burst -> no pops during the gap; the burst still delivers exactly 8 words.
REQ-038 Assert rst_n=0 at beat 4 of a burst -> all outputs go to reset values immediately; the next burst starts at wr_addr=0.
